// File: rtl/lsq_pkg.sv
// lsq_pkg: shared opcodes, memory size codes, FSM state and the
// store data formatter used by the load/store queue.
package lsq_pkg;

    localparam logic [5:0] OP_LB  = 6'b100001;
    localparam logic [5:0] OP_LBU = 6'b101010;
    localparam logic [5:0] OP_LH  = 6'b101011;
    localparam logic [5:0] OP_LHU = 6'b101100;
    localparam logic [5:0] OP_LW  = 6'b111101;
    localparam logic [5:0] OP_SB  = 6'b101111;
    localparam logic [5:0] OP_SH  = 6'b110000;
    localparam logic [5:0] OP_SW  = 6'b110001;

    localparam logic [1:0] MSZ_WORD = 2'd0;
    localparam logic [1:0] MSZ_BYTE = 2'd1;
    localparam logic [1:0] MSZ_HALF = 2'd2;
    localparam logic [1:0] MSZ_TRI  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        DRAIN
    } lsq_state_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [1:0]  size;
    } st_fmt_t;

    // Unknown store ops go out as a full word.
    function automatic st_fmt_t store_fmt(
        input logic [5:0]  op,
        input logic [31:0] d
    );
        st_fmt_t f;
        unique case (1'b1)
            (op == OP_SB): begin
                f.wdata = {24'b0, d[7:0]};
                f.size  = MSZ_BYTE;
            end
            (op == OP_SH): begin
                f.wdata = {16'b0, d[15:0]};
                f.size  = MSZ_HALF;
            end
            default: begin
                f.wdata = d;
                f.size  = MSZ_WORD;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsq_load_align.sv
// lsq_load_align: big-endian load data extraction and extension.
// Ports: op, offset (addr[1:0]), rdata in; wb_data out. Combinational.
module lsq_load_align
    import lsq_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] wb_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        unique case (offset)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = offset[1] ? rdata[15:0] : rdata[31:16];
        unique case (1'b1)
            (op == OP_LB):  wb_data = {{24{b[7]}}, b};
            (op == OP_LBU): wb_data = {24'b0, b};
            (op == OP_LH):  wb_data = {{16{h[15]}}, h};
            (op == OP_LHU): wb_data = {16'b0, h};
            default:        wb_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsq_unit.sv
// lsq_unit: in-order load/store queue with ALU address capture,
// CDB operand snooping, retirement FSM, memory port and writeback.
// Ports: CLK/RESET, enq_*, alu_*, cdb_*, retire_in/head_ready,
// mem_*, wb_*, flush, count/empty/full.
module lsq_unit
    import lsq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int N_ALU   = 2,
    parameter int N_CDB   = 2,
    parameter int UID_W   = 6,
    parameter int REGID_W = 6
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [UID_W-1:0]           enq_uid,
    input  logic                       enq_is_store,
    input  logic [5:0]                 enq_op,
    input  logic [REGID_W-1:0]         enq_dst,
    input  logic [REGID_W-1:0]         enq_src,
    input  logic [31:0]                enq_src_data,
    input  logic                       enq_src_valid,
    input  logic [N_ALU-1:0]           alu_valid,
    input  logic [N_ALU*UID_W-1:0]     alu_uid,
    input  logic [N_ALU*32-1:0]        alu_addr,
    input  logic [N_CDB-1:0]           cdb_valid,
    input  logic [N_CDB*REGID_W-1:0]   cdb_reg,
    input  logic [N_CDB*32-1:0]        cdb_data,
    input  logic                       retire_in,
    output logic                       head_ready,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [1:0]                 mem_size,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_rvalid,
    output logic                       wb_valid,
    output logic [REGID_W-1:0]         wb_reg,
    output logic [31:0]                wb_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    lsq_state_t state;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic               e_valid [DEPTH];
    logic [UID_W-1:0]   e_uid   [DEPTH];
    logic               e_st    [DEPTH];
    logic [5:0]         e_op    [DEPTH];
    logic [REGID_W-1:0] e_dst   [DEPTH];
    logic [REGID_W-1:0] e_src   [DEPTH];
    logic [31:0]        e_sd    [DEPTH];
    logic               e_sv    [DEPTH];
    logic [31:0]        e_addr  [DEPTH];
    logic               e_av    [DEPTH];

    logic               n_valid [DEPTH];
    logic [UID_W-1:0]   n_uid   [DEPTH];
    logic               n_st    [DEPTH];
    logic [5:0]         n_op    [DEPTH];
    logic [REGID_W-1:0] n_dst   [DEPTH];
    logic [REGID_W-1:0] n_src   [DEPTH];
    logic [31:0]        n_sd    [DEPTH];
    logic               n_sv    [DEPTH];
    logic [31:0]        n_addr  [DEPTH];
    logic               n_av    [DEPTH];

    logic        enq_fire;
    logic        issue;
    logic        deq;
    logic        live;
    logic        ahit;
    logic [31:0] ld_data;
    st_fmt_t     sfmt;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign enq_ready = !full && !flush;
    assign enq_fire  = enq_valid && enq_ready;

    assign head_ready = !empty && (state == IDLE) && e_av[head]
                        && (!e_st[head] || e_sv[head]);

    // Flush wins over a same-cycle retirement.
    assign issue = retire_in && head_ready && !flush;
    assign deq   = (issue && e_st[head])
                   || ((state == LOAD_WAIT) && mem_rvalid);

    assign sfmt = store_fmt(e_op[head], e_sd[head]);

    lsq_load_align u_align (
        .op      (e_op[head]),
        .offset  (e_addr[head][1:0]),
        .rdata   (mem_rdata),
        .wb_data (ld_data)
    );

    // Next entry contents: enqueue first, so the new entry also
    // sees this cycle's ALU and CDB broadcasts. Ascending port
    // search with a hit flag gives the lowest port priority.
    always_comb begin
        n_valid = e_valid;
        n_uid   = e_uid;
        n_st    = e_st;
        n_op    = e_op;
        n_dst   = e_dst;
        n_src   = e_src;
        n_sd    = e_sd;
        n_sv    = e_sv;
        n_addr  = e_addr;
        n_av    = e_av;
        live    = 1'b0;
        ahit    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (deq && PW'(i) == head)
                n_valid[i] = 1'b0;
            if (enq_fire && PW'(i) == tail) begin
                n_valid[i] = 1'b1;
                n_uid[i]   = enq_uid;
                n_st[i]    = enq_is_store;
                n_op[i]    = enq_op;
                n_dst[i]   = enq_dst;
                n_src[i]   = enq_src;
                n_sd[i]    = enq_src_data;
                n_sv[i]    = enq_src_valid;
                n_addr[i]  = '0;
                n_av[i]    = 1'b0;
            end
            live = e_valid[i] || (enq_fire && PW'(i) == tail);
            ahit = 1'b0;
            for (int k = 0; k < N_ALU; k++) begin
                if (!ahit && live && alu_valid[k]
                    && alu_uid[k*UID_W +: UID_W] == n_uid[i]) begin
                    n_addr[i] = alu_addr[k*32 +: 32];
                    n_av[i]   = 1'b1;
                    ahit      = 1'b1;
                end
            end
            for (int j = 0; j < N_CDB; j++) begin
                if (live && !n_sv[i] && cdb_valid[j]
                    && cdb_reg[j*REGID_W +: REGID_W] == n_src[i]) begin
                    n_sd[i] = cdb_data[j*32 +: 32];
                    n_sv[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                e_valid[i] <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                e_valid[i] <= 1'b0;
        end else begin
            e_valid <= n_valid;
            head    <= head + PW'(deq);
            tail    <= tail + PW'(enq_fire);
            count   <= count + CW'(enq_fire) - CW'(deq);
        end
    end

    // Payload is only meaningful under e_valid, so it needs no reset.
    always_ff @(posedge CLK) begin
        e_uid  <= n_uid;
        e_st   <= n_st;
        e_op   <= n_op;
        e_dst  <= n_dst;
        e_src  <= n_src;
        e_sd   <= n_sd;
        e_sv   <= n_sv;
        e_addr <= n_addr;
        e_av   <= n_av;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= '0;
            wb_valid  <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
        end else begin
            mem_write <= 1'b0;
            wb_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue && e_st[head]) begin
                        mem_write <= 1'b1;
                        mem_addr  <= e_addr[head];
                        mem_wdata <= sfmt.wdata;
                        mem_size  <= sfmt.size;
                    end else if (issue) begin
                        mem_read <= 1'b1;
                        mem_addr <= {e_addr[head][31:2], 2'b00};
                        state    <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        mem_read <= 1'b0;
                        state    <= IDLE;
                        if (!flush) begin
                            wb_valid <= 1'b1;
                            wb_reg   <= e_dst[head];
                            wb_data  <= ld_data;
                        end
                    end else if (flush) begin
                        mem_read <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
